// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//
// Raster timing generator and pixel scanout for a VGA-style display. A pair
// of free-running counters walk the frame. Pixels are popped from an
// upstream FIFO whose read data returns RD_LATENCY clocks after the pop
// request. The sync/enable strobes are delayed by the same amount so that
// every output is aligned with the returned pixel word. An empty FIFO never
// stalls the raster: the missing pixel is shown as 0 and a sticky underflow
// flag is raised.
//
// Parameters
//   WIDTH                      pixel / FIFO data width
//   H_ACTIVE,H_FP,H_SYNC,H_BP  horizontal timing in clocks
//   V_ACTIVE,V_FP,V_SYNC,V_BP  vertical timing in lines
//   RD_LATENCY                 FIFO read latency in clocks (legal 1..4)
//
// Ports
//   clk            pixel clock, rising edge
//   rst            asynchronous active-high reset
//   enable         run scanout; when low the raster is parked at (0,0)
//   fifo_empty     upstream FIFO empty flag
//   fifo_rd_data   upstream FIFO read data
//   clr_underflow  clears the sticky underflow flag (a new underflow wins)
//   fifo_rd_ena    pop request to the FIFO (combinational)
//   hsync, vsync   active-low sync strobes
//   de             data enable, high during active video
//   pixel          pixel value, 0 in blanking and for underflowed pixels
//   frame_start    one-cycle pulse on the first pixel of each frame
//   underflow      sticky flag: a pixel was due while the FIFO was empty
//
// All registered outputs are RD_LATENCY+1 clocks behind the counter
// position that produced them.
// ---------------------------------------------------------------------------
module vga_scanout #(
    parameter int WIDTH      = 8,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int RD_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             clr_underflow,
    output logic             fifo_rd_ena,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [WIDTH-1:0] pixel,
    output logic             frame_start,
    output logic             underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One spare bit so the sync-end boundary still fits when the back porch is 0.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Per-pixel attributes carried alongside the FIFO read latency.
    // rd marks that a pop was issued for this slot, uf that the pixel was missed.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
        logic rd;
        logic uf;
    } stage_t;

    localparam stage_t STAGE_RESET = '{hs: 1'b1, vs: 1'b1, default: 1'b0};

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    stage_t        stage0;
    stage_t        pipe [RD_LATENCY];
    stage_t        tail;

    // Raster counters. Disabling parks the raster at (0,0) so that a
    // re-enable always begins a fresh frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Stage-0 decode of the current raster position. The pop request is
    // suppressed while reset is asserted because the parked counters
    // would otherwise decode as an active pixel.
    always_comb begin
        logic active;
        active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        stage0.hs = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
        stage0.vs = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
        stage0.de = enable && active;
        stage0.fs = enable && (h_cnt == '0) && (v_cnt == '0);
        stage0.rd = !rst && enable && active && !fifo_empty;
        stage0.uf = enable && active && fifo_empty;
    end

    assign fifo_rd_ena = stage0.rd;

    // Delay line matching the FIFO read latency; its last entry describes
    // the pixel whose data is on fifo_rd_data this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe[i] <= STAGE_RESET;
            end
        end else begin
            pipe[0] <= stage0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail = pipe[RD_LATENCY-1];

    // Output register. Slots with no pop issued (blanking or underflow)
    // show 0 rather than whatever the FIFO happens to drive. The underflow
    // flag is set from the delayed event so it rises together with the
    // zeroed pixel; a set on the same clock as a clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
            pixel       <= '0;
            underflow   <= 1'b0;
        end else begin
            hsync       <= tail.hs;
            vsync       <= tail.vs;
            de          <= tail.de;
            frame_start <= tail.fs;
            pixel       <= tail.rd ? fifo_rd_data : '0;
            if (tail.uf) begin
                underflow <= 1'b1;
            end else if (clr_underflow) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter WIDTH, default 8, sets the pixel word width and matches the FIFO data width.
REQ-002 Parameters H_ACTIVE, H_FP, H_SYNC, H_BP (defaults 640, 16, 96, 48) set the horizontal timing in clocks.
REQ-003 Parameters V_ACTIVE, V_FP, V_SYNC, V_BP (defaults 480, 10, 2, 33) set the vertical timing in lines.
REQ-004 Parameter RD_LATENCY, default 2, sets the clocks from fifo_rd_ena high to valid fifo_rd_data; the legal range is 1 to 4.
REQ-005 Port clk, input, 1 bit, is the single pixel clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit, is the reset; it is asynchronous and active-high.
REQ-007 Port enable, input, 1 bit, runs scanout when high.
REQ-008 Port fifo_empty, input, 1 bit, is the empty flag of the upstream pixel FIFO.
REQ-009 Port fifo_rd_data, input, WIDTH bits, is the pixel word returned by the FIFO.
REQ-010 Port clr_underflow, input, 1 bit, clears the underflow flag.
REQ-011 Port fifo_rd_ena, output, 1 bit, is the pop request to the FIFO.
REQ-012 Port hsync, output, 1 bit, is horizontal sync, active-low.
REQ-013 Port vsync, output, 1 bit, is vertical sync, active-low.
REQ-014 Port de, output, 1 bit, is data enable and is high during active video.
REQ-015 Port pixel, output, WIDTH bits, is the pixel value.
REQ-016 Port frame_start, output, 1 bit, is a one-cycle pulse marking the first pixel of each frame.
REQ-017 Port underflow, output, 1 bit, is a sticky flag set when a pixel is needed and the FIFO is empty.

Function
REQ-018 h_cnt SHALL count 0 to H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, then wrap to 0.
REQ-019 v_cnt SHALL increment when h_cnt wraps, count 0 to V_TOTAL-1 (V_TOTAL is the sum of the V parameters), then wrap to 0.
REQ-020 When enable is low, both counters SHALL hold at 0 and fifo_rd_ena SHALL be 0; operation resumes from (0,0) when enable goes high.
REQ-021 Stage-0 active SHALL be high when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-022 fifo_rd_ena SHALL equal enable AND active AND NOT fifo_empty, evaluated combinationally in the same cycle, and SHALL never be high while fifo_empty is high.
REQ-023 Stage-0 hsync SHALL be 0 when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), otherwise 1.
REQ-024 Stage-0 vsync SHALL be 0 when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), otherwise 1.
REQ-025 Stage-0 frame_start SHALL be high when h_cnt = 0, v_cnt = 0, and enable is high.
REQ-026 hsync, vsync, de (from active), frame_start, and a read-issued bit SHALL pass through a RD_LATENCY-deep register pipeline so they align with fifo_rd_data.
REQ-027 At the pipeline output, pixel SHALL be registered from fifo_rd_data when the read-issued bit is 1, and SHALL be 0 otherwise.
REQ-028 Consequently, pixel SHALL be 0 during blanking and on underflowed pixels.
REQ-029 underflow SHALL be set on any clock where stage-0 active and enable are high and fifo_empty is high.
REQ-030 underflow SHALL be cleared by clr_underflow; if set and clear coincide, set wins.
REQ-031 Total latency from the counter position to the outputs SHALL be exactly RD_LATENCY+1 clocks for every output signal.
REQ-032 The block SHALL not stall or slip timing on underflow; each missing pixel is replaced by 0 and the FIFO is not read for it.

Reset
REQ-033 While rst is high, the block SHALL hold h_cnt=0, v_cnt=0, fifo_rd_ena=0, hsync=1, vsync=1, de=0, pixel=0, frame_start=0, underflow=0, and clear every pipeline stage.
REQ-034 Reset SHALL take effect asynchronously, including mid-line.
REQ-035 After rst deasserts, scanout SHALL start at (0,0) on the next enabled clock with no partial-frame artefacts on the outputs.

Verification
REQ-036 The bench SHALL use H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, and RD_LATENCY=2.
REQ-037 Scenario, timing: enable=1 with the FIFO never empty -> hsync is low for output clocks 5-6 of each 8-clock line, vsync is low for line 3 of each 5-line frame, de is high for 4 clocks on lines 0-1 only, and frame_start pulses every 40 clocks.
REQ-038 Scenario, data path: FIFO model returns 0x11, 0x22, ... with a 2-clock latency -> pixel shows 0x11, 0x22, 0x33, 0x44 on the de-high clocks of line 0, and 0x00 while de is low.
REQ-039 Scenario, underflow: fifo_empty is forced high for the third active pixel -> fifo_rd_ena stays 0 on that clock, pixel=0x00 in that slot, underflow=1 and stays 1, and the following pixels resume the sequence unshifted.
REQ-040 Scenario, clear: pulse clr_underflow with no new underflow -> underflow returns to 0; clr_underflow asserted in the same cycle as a new underflow -> underflow stays 1.
REQ-041 Scenario, async reset: assert rst mid-line 1 between clock edges -> all outputs go to their reset values immediately, and after release the first frame_start appears 3 clocks after the first enabled clock.
REQ-042 Scenario, enable: drop enable mid-frame for 10 clocks -> no FIFO reads occur, and timing restarts at (0,0) when enable returns.
